shared_bus_arbiter: RTL and testbench
=====================================

// Module: shared_bus_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for one shared tri-state interconnect bus
//  (e.g. a two-ended iBus driven by left/right drivers). Grants one requester
//  at a time, enforces a max tenure and bus turnaround, and models a charge-
//  storage keeper (trireg-style) that holds the last driven value until decay.
// PARAMETERS
//  NREQ      4   number of requesters (>=2)
//  DW        16  bus data width
//  TURN      1   idle turnaround cycles between tenures (0 allowed)
//  MAX_HOLD  8   max cycles of one tenure before forced release (>=1)
//  DECAY     50  idle cycles the keeper holds the last value before decay (>=1)
// PORTS
//  clk        in   1        clock, all logic on rising edge
//  rst        in   1        synchronous reset, active-high
//  req        in   NREQ     request, one bit per requester, level
//  last       in   NREQ     requester marks its final beat (valid only with grant)
//  wdata      in   NREQ*DW  requester data, slice i = wdata[i*DW +: DW]
//  grant      out  NREQ     one-hot or zero, registered
//  bus_oe     out  1        bus driven this cycle (== |grant)
//  bus_data   out  DW       driven value, or kept value when bus_oe=0
//  bus_valid  out  1        bus_data holds driven or still-charged value
//  timeout    out  1        one-cycle pulse on forced release at MAX_HOLD
// BEHAVIOUR
//  Reset: grant=0, bus_oe=0, bus_data=0, bus_valid=0, timeout=0, ptr=0, state=IDLE.
//  Reset mid-tenure drops grant at the same edge; no timeout pulse.
//  States: IDLE -> GRANT -> TURN -> IDLE (TURN skipped when TURN=0).
//  IDLE: if |req, pick first set req[i] scanning ptr, ptr+1, ... mod NREQ;
//   grant[i] high from the next edge (1-cycle latency); hold_cnt=0.
//  GRANT: bus_oe=1, bus_data=wdata[i], bus_valid=1. Tenure ends at the edge where
//   (req[i]&last[i]) or !req[i] or hold_cnt==MAX_HOLD-1; the last case also
//   pulses timeout (if last[i] is set on that cycle, last wins; no timeout).
//   On exit: grant=0, ptr=(i+1) mod NREQ, turn_cnt=0.
//  TURN: grant=0, bus_oe=0 for exactly TURN cycles; req is ignored; -> IDLE.
//   Earliest regrant: TURN+1 cycles after tenure end.
//  Keeper: when bus_oe=0, bus_data holds the last driven value and decay_cnt
//   counts idle cycles; at decay_cnt==DECAY, bus_data=0 and bus_valid=0.
//   Any new tenure reloads bus_data and clears decay_cnt. Never driven since
//   reset: bus_valid=0.
//  last[] and wdata[] are ignored for non-granted requesters; grant is never
//   more than one-hot.
//  Counter widths: $clog2(MAX_HOLD+1), $clog2(TURN+1), $clog2(DECAY+1); no wrap.
// STRUCTURE
//  Package shared_bus_pkg: state enum {IDLE,GRANT,TURN}; width localparams.
//  Sub-module rr_pick: combinational round-robin picker (req, ptr -> onehot,
//   idx, any). Arbiter FSM, counters and keeper stay in the top module.
// TESTING
//  1 rst=1 for 2 cycles with req=4'b1111 -> grant=0, bus_oe=0, bus_data=0,
//    bus_valid=0, timeout=0.
//  2 req=4'b0010, wdata[1]=16'hA5A5, last on 3rd granted cycle -> grant=4'b0010
//    1 cycle after req for 3 cycles, bus_data=16'hA5A5; then 1 TURN cycle with
//    grant=0.
//  3 req=4'b1111 held, last=4'b1111 -> grants 0001,0010,0100,1000,0001, each
//    1 cycle, separated by 1 TURN + 1 IDLE cycle.
//  4 req=4'b0001 held, last=0 -> grant high exactly 8 cycles; timeout pulses at
//    release; next grant to 0001 2 cycles after release.
//  5 tenure ends with bus_data=16'h1234, no req -> bus_data=16'h1234,
//    bus_valid=1 for 50 idle cycles, then bus_data=0, bus_valid=0.
//  6 rst=1 in 4th cycle of tenure of requester 2 -> grant=0 next cycle, no
//    timeout; with req=4'b1111 afterwards, first grant is 4'b0001.

Source files
------------

// File: rtl/shared_bus_pkg.sv
// Shared definitions for the shared-bus arbiter: FSM state encoding and
// helpers that size the index and counter fields.
package shared_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    // Counter able to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Index able to address n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shared_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NREQ.
module rr_pick
    import shared_bus_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    localparam logic [IW:0]     NREQ_W  = (IW + 1)'(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT = NREQ'(1);

    logic [2*NREQ-1:0] dbl_s;
    logic [NREQ-1:0]   rot_s;
    logic [IW-1:0]     off_s;
    logic [IW:0]       sum_s;
    logic [IW:0]       wrap_s;

    // Rotate requests so that bit 0 is the requester at ptr.
    always_comb begin
        dbl_s = {req, req} >> ptr;
        rot_s = dbl_s[NREQ-1:0];
    end

    // Lowest set rotated bit wins; map the offset back to an absolute index.
    always_comb begin
        off_s = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? IW'(i) : off_s;
        end
        sum_s  = {1'b0, ptr} + {1'b0, off_s};
        wrap_s = (sum_s >= NREQ_W) ? (sum_s - NREQ_W) : sum_s;
        idx    = wrap_s[IW-1:0];
        any    = |req;
        onehot = any ? (ONE_HOT << idx) : '0;
    end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter for one shared bus with bounded tenure, idle turnaround
// and a charge keeper that holds the last driven value until it decays.
module shared_bus_arbiter
    import shared_bus_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DW       = 16,
    parameter int TURN     = 1,
    parameter int MAX_HOLD = 8,
    parameter int DECAY    = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    last,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    grant,
    output logic               bus_oe,
    output logic [DW-1:0]      bus_data,
    output logic               bus_valid,
    output logic               timeout
);

    localparam int IW  = idx_width(NREQ);
    localparam int HW  = cnt_width(MAX_HOLD);
    localparam int TW  = cnt_width(TURN);
    localparam int DCW = cnt_width(DECAY);

    localparam logic [IW-1:0]  IDX_MAX    = IW'(NREQ - 1);
    localparam logic [IW-1:0]  IDX_ONE    = IW'(1);
    localparam logic [HW-1:0]  HOLD_LAST  = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0]  HOLD_ONE   = HW'(1);
    localparam logic [TW-1:0]  TURN_LAST  = TW'((TURN > 0) ? TURN - 1 : 0);
    localparam logic [TW-1:0]  TURN_ONE   = TW'(1);
    localparam logic [DCW-1:0] DECAY_LAST = DCW'(DECAY - 1);
    localparam logic [DCW-1:0] DECAY_FULL = DCW'(DECAY);
    localparam logic [DCW-1:0] DECAY_ONE  = DCW'(1);

    state_t          state_r, next_state_s;
    logic [NREQ-1:0] grant_r;
    logic [IW-1:0]   gidx_r;
    logic [IW-1:0]   ptr_r;
    logic [HW-1:0]   hold_cnt_r;
    logic [TW-1:0]   turn_cnt_r;
    logic [DCW-1:0]  decay_cnt_r;
    logic [DW-1:0]   keep_data_r;
    logic            keep_valid_r;
    logic            timeout_r;

    logic [NREQ-1:0] pick_onehot_s;
    logic [IW-1:0]   pick_idx_s;
    logic            pick_any_s;
    logic            cur_req_s;
    logic            cur_last_s;
    logic [DW-1:0]   sel_data_s;
    logic            hold_max_s;
    logic            tenure_end_s;
    logic            force_rel_s;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_r),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    // Request, last flag and data of the current owner; other requesters are invisible.
    always_comb begin
        cur_req_s  = 1'b0;
        cur_last_s = 1'b0;
        sel_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            cur_req_s  = (gidx_r == IW'(i)) ? req[i]            : cur_req_s;
            cur_last_s = (gidx_r == IW'(i)) ? last[i]           : cur_last_s;
            sel_data_s = (gidx_r == IW'(i)) ? wdata[i*DW +: DW] : sel_data_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                next_state_s = pick_any_s ? ST_GRANT : ST_IDLE;
            end
            ST_GRANT: begin
                if (tenure_end_s) begin
                    next_state_s = (TURN > 0) ? ST_TURN : ST_IDLE;
                end else begin
                    next_state_s = ST_GRANT;
                end
            end
            ST_TURN: begin
                next_state_s = (turn_cnt_r == TURN_LAST) ? ST_IDLE : ST_TURN;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: tenure end conditions; a final beat beats the hold limit.
    always_comb begin
        hold_max_s = (hold_cnt_r == HOLD_LAST);
        if (state_r == ST_GRANT) begin
            tenure_end_s = !cur_req_s || cur_last_s || hold_max_s;
            force_rel_s  = cur_req_s && !cur_last_s && hold_max_s;
        end else begin
            tenure_end_s = 1'b0;
            force_rel_s  = 1'b0;
        end
    end

    // Grant, pointer, tenure/turnaround counters and timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_r    <= '0;
            gidx_r     <= '0;
            ptr_r      <= '0;
            hold_cnt_r <= '0;
            turn_cnt_r <= '0;
            timeout_r  <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        grant_r    <= pick_onehot_s;
                        gidx_r     <= pick_idx_s;
                        hold_cnt_r <= '0;
                    end else begin
                        grant_r <= '0;
                    end
                end
                ST_GRANT: begin
                    if (tenure_end_s) begin
                        grant_r    <= '0;
                        ptr_r      <= (gidx_r == IDX_MAX) ? '0 : gidx_r + IDX_ONE;
                        turn_cnt_r <= '0;
                        timeout_r  <= force_rel_s;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                    end
                end
                ST_TURN: begin
                    grant_r <= '0;
                    if (turn_cnt_r != TURN_LAST) begin
                        turn_cnt_r <= turn_cnt_r + TURN_ONE;
                    end else begin
                        turn_cnt_r <= turn_cnt_r;
                    end
                end
                default: begin
                    grant_r <= '0;
                end
            endcase
        end
    end

    // Keeper: capture while driven, then count idle cycles until the charge decays.
    always_ff @(posedge clk) begin
        if (rst) begin
            keep_data_r  <= '0;
            keep_valid_r <= 1'b0;
            decay_cnt_r  <= '0;
        end else if (|grant_r) begin
            keep_data_r  <= sel_data_s;
            keep_valid_r <= 1'b1;
            decay_cnt_r  <= '0;
        end else if (keep_valid_r) begin
            if (decay_cnt_r == DECAY_LAST) begin
                keep_data_r  <= '0;
                keep_valid_r <= 1'b0;
                decay_cnt_r  <= DECAY_FULL;
            end else begin
                decay_cnt_r <= decay_cnt_r + DECAY_ONE;
            end
        end else begin
            decay_cnt_r <= decay_cnt_r;
        end
    end

    assign grant     = grant_r;
    assign bus_oe    = |grant_r;
    assign bus_data  = bus_oe ? sel_data_s : keep_data_r;
    assign bus_valid = bus_oe | keep_valid_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Self-checking bench for shared_bus_arbiter: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_shared_bus_arbiter;

    localparam int NREQ     = 4;
    localparam int DW       = 16;
    localparam int TURN     = 1;
    localparam int MAX_HOLD = 8;
    localparam int DECAY    = 50;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ-1:0]    last = '0;
    logic [NREQ*DW-1:0] wdata = '0;
    logic [NREQ-1:0]    grant;
    logic               bus_oe;
    logic [DW-1:0]      bus_data;
    logic               bus_valid;
    logic               timeout;

    int checks = 0;
    int errors = 0;

    // Behavioural model: who owns the bus, how long, and what the keeper holds.
    int            m_owner = -1;
    int            m_held = 0;
    int            m_quiet = 0;
    int            m_ptr = 0;
    int            m_idle = 0;
    logic [DW-1:0] m_keep = '0;
    bit            m_keep_valid = 1'b0;
    bit            m_timeout = 1'b0;

    shared_bus_arbiter #(
        .NREQ(NREQ), .DW(DW), .TURN(TURN), .MAX_HOLD(MAX_HOLD), .DECAY(DECAY)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .last(last), .wdata(wdata),
        .grant(grant), .bus_oe(bus_oe), .bus_data(bus_data),
        .bus_valid(bus_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] slice(input int i);
        return wdata[i*DW +: DW];
    endfunction

    function automatic void model_reset();
        m_owner = -1; m_held = 0; m_quiet = 0; m_ptr = 0; m_idle = 0;
        m_keep = '0; m_keep_valid = 1'b0; m_timeout = 1'b0;
    endfunction

    function automatic void model_step();
        m_timeout = 1'b0;
        if (m_owner >= 0) begin
            m_keep = slice(m_owner);
            m_keep_valid = 1'b1;
            m_idle = 0;
            m_held++;
            if (!req[m_owner] || last[m_owner] || m_held == MAX_HOLD) begin
                m_timeout = req[m_owner] && !last[m_owner];
                m_ptr = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_quiet = TURN;
            end
        end else begin
            if (m_keep_valid) begin
                m_idle++;
                if (m_idle == DECAY) begin
                    m_keep_valid = 1'b0;
                    m_keep = '0;
                end
            end
            if (m_quiet > 0) begin
                m_quiet--;
            end else if (req != '0) begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    if (req[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
                end
                m_held = 0;
            end
        end
    endfunction

    function automatic logic [NREQ-1:0] exp_grant();
        logic [NREQ-1:0] one;
        one = 1;
        return (m_owner >= 0) ? (one << m_owner) : '0;
    endfunction

    function automatic logic [DW-1:0] exp_data();
        return (m_owner >= 0) ? slice(m_owner) : m_keep;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = '0; last = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111;
        tick(); tick();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b exp=0", bus_oe); end
        checks++; if (bus_data !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h exp=0000", bus_data); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus_valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        rst = 1'b0; req = '0;
        tick();
    endtask

    task automatic test_single();
        apply_reset();
        wdata[1*DW +: DW] = 16'hA5A5;
        req = 4'b0010;
        tick();
        for (int c = 1; c <= 3; c++) begin
            checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL single_grant c=%0d got=%b exp=0010", c, grant); end
            checks++; if (bus_data !== 16'hA5A5) begin errors++; $display("FAIL single_data c=%0d got=%h exp=a5a5", c, bus_data); end
            if (c == 3) last = 4'b0010;
            tick();
        end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_turn_grant got=%b exp=0000", grant); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL single_timeout got=%b exp=0", timeout); end
        checks++; if (bus_data !== 16'hA5A5 || bus_valid !== 1'b1) begin errors++; $display("FAIL single_keep got=%h/%b exp=a5a5/1", bus_data, bus_valid); end
        req = '0; last = '0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] one;
        logic [NREQ-1:0] exp;
        apply_reset();
        for (int i = 0; i < NREQ; i++) wdata[i*DW +: DW] = DW'(16'h1000 + i);
        req = 4'b1111; last = 4'b1111;
        one = 1;
        tick();
        for (int c = 0; c <= 12; c++) begin
            exp = (c % 3 == 0) ? (one << ((c / 3) % NREQ)) : '0;
            checks++; if (grant !== exp) begin errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, grant, exp); end
            if (c % 3 == 0) begin
                checks++; if (bus_data !== DW'(16'h1000 + (c / 3) % NREQ)) begin errors++; $display("FAIL rr_data c=%0d got=%h", c, bus_data); end
            end
            tick();
        end
        req = '0; last = '0;
    endtask

    task automatic test_timeout();
        logic [NREQ-1:0] exp;
        apply_reset();
        wdata[0 +: DW] = DW'($urandom);
        req = 4'b0001; last = '0;
        tick();
        for (int c = 1; c <= 11; c++) begin
            exp = (c <= MAX_HOLD || c == MAX_HOLD + 3) ? 4'b0001 : 4'b0000;
            checks++; if (grant !== exp) begin errors++; $display("FAIL hold_grant c=%0d got=%b exp=%b", c, grant, exp); end
            checks++; if (timeout !== (c == MAX_HOLD + 1)) begin errors++; $display("FAIL hold_timeout c=%0d got=%b exp=%b", c, timeout, (c == MAX_HOLD + 1)); end
            if (c < 11) tick();
        end
        req = '0;
        tick();
    endtask

    task automatic test_keeper_decay();
        apply_reset();
        wdata[2*DW +: DW] = 16'h1234;
        req = 4'b0100;
        tick();
        last = 4'b0100;
        checks++; if (bus_data !== 16'h1234 || bus_oe !== 1'b1) begin errors++; $display("FAIL keep_drive got=%h/%b exp=1234/1", bus_data, bus_oe); end
        tick();
        req = '0; last = '0;
        for (int k = 1; k <= DECAY + 1; k++) begin
            if (k <= DECAY) begin
                checks++; if (bus_data !== 16'h1234 || bus_valid !== 1'b1) begin errors++; $display("FAIL keep_hold k=%0d got=%h/%b exp=1234/1", k, bus_data, bus_valid); end
            end else begin
                checks++; if (bus_data !== 16'h0000 || bus_valid !== 1'b0) begin errors++; $display("FAIL keep_decay k=%0d got=%h/%b exp=0000/0", k, bus_data, bus_valid); end
            end
            for (int i = 0; i < NREQ; i++) wdata[i*DW +: DW] = DW'($urandom);
            if (k <= DECAY) tick();
        end
    endtask

    task automatic test_reset_mid_tenure();
        apply_reset();
        req = 4'b0100; last = '0;
        tick(); tick(); tick(); tick();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL midrst_pre got=%b exp=0100", grant); end
        rst = 1'b1;
        tick();
        checks++; if (grant !== 4'b0000 || timeout !== 1'b0) begin errors++; $display("FAIL midrst_drop got=%b/%b exp=0000/0", grant, timeout); end
        rst = 1'b0; req = 4'b1111; last = 4'b1111;
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL midrst_first got=%b exp=0001", grant); end
        req = '0; last = '0;
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if (c >= 200 && c < 270) begin
                req = '0; last = '0;
            end else if (c >= 400 && c < 500) begin
                req = 4'b1111;
                last = ($urandom_range(0, 19) == 0) ? NREQ'($urandom) : '0;
            end else begin
                req = NREQ'($urandom) & NREQ'($urandom | $urandom);
                last = NREQ'($urandom) & NREQ'($urandom);
            end
            rst = (c == 550);
            for (int i = 0; i < NREQ; i++) wdata[i*DW +: DW] = DW'($urandom);
            tick();
            checks++; if (grant !== exp_grant()) begin errors++; $display("FAIL rand_grant c=%0d got=%b exp=%b", c, grant, exp_grant()); end
            checks++; if (bus_oe !== (m_owner >= 0)) begin errors++; $display("FAIL rand_oe c=%0d got=%b exp=%b", c, bus_oe, (m_owner >= 0)); end
            checks++; if (bus_data !== exp_data()) begin errors++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, bus_data, exp_data()); end
            checks++; if (bus_valid !== (m_owner >= 0 || m_keep_valid)) begin errors++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, bus_valid, (m_owner >= 0 || m_keep_valid)); end
            checks++; if (timeout !== m_timeout) begin errors++; $display("FAIL rand_timeout c=%0d got=%b exp=%b", c, timeout, m_timeout); end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_keeper_decay();
        test_reset_mid_tenure();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
